lcd_host_ctrl: RTL and testbench

- Command-issuing host for the LCD controller. It drives cmd/cmd_valid/datain and consumes dataout/output_valid/busy.
- Accepts single-opcode requests from an upstream sequencer.
- For LOAD, streams the 12x9 (108-pixel) image from a synchronous image ROM/RAM read port.
- Captures each 16-pixel display window and presents it, indexed, to downstream logic, with completion and timeout status.

---
 rtl/lcd_host_ctrl_pkg.sv | 26 ++
 rtl/lcd_host_ctrl_if.sv | 31 +++
 rtl/lcd_host_timeout.sv | 43 ++++
 rtl/lcd_host_ctrl.sv | 155 +++++++++++++++
 tb/tb_lcd_host_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_host_ctrl_pkg.sv
// Shared opcodes, image geometry and FSM state type for the LCD host controller.
package lcd_pkg;

  localparam logic [2:0] CMD_LOAD   = 3'd0;
  localparam logic [2:0] CMD_ZOOMIN = 3'd1;
  localparam logic [2:0] CMD_ZOOMFT = 3'd2;
  localparam logic [2:0] CMD_RIGHT  = 3'd3;
  localparam logic [2:0] CMD_LEFT   = 3'd4;
  localparam logic [2:0] CMD_UP     = 3'd5;
  localparam logic [2:0] CMD_DOWN   = 3'd6;
  localparam logic [2:0] CMD_BAD    = 3'd7;

  localparam int unsigned IMG_W   = 12;
  localparam int unsigned IMG_H   = 9;
  localparam int unsigned IMG_PIX = IMG_W * IMG_H;
  localparam int unsigned WIN_PIX = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD,
    ST_COLLECT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lcd_host_ctrl_if.sv
// Bundles the upstream request, image-source, LCD command and window-capture signals.
interface lcd_host_ctrl_if;
  logic       req_valid;
  logic [2:0] req_cmd;
  logic       req_ready;
  logic [6:0] img_addr;
  logic [7:0] img_rdata;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic [7:0] dataout;
  logic       output_valid;
  logic [7:0] pix_out;
  logic [3:0] pix_idx;
  logic       pix_valid;
  logic       frame_done;
  logic       err_timeout;

  modport master (
    input  req_valid, req_cmd, img_rdata, busy, dataout, output_valid,
    output req_ready, img_addr, cmd, cmd_valid, datain,
           pix_out, pix_idx, pix_valid, frame_done, err_timeout
  );

  modport slave (
    output req_valid, req_cmd, img_rdata, busy, dataout, output_valid,
    input  req_ready, img_addr, cmd, cmd_valid, datain,
           pix_out, pix_idx, pix_valid, frame_done, err_timeout
  );
endinterface

// File: rtl/lcd_host_timeout.sv
// Loadable down-counter: armed by load, fires a single expire pulse when it reaches zero while enabled.
module lcd_host_timeout #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clear_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         armed_q, armed_d;

  assign expire_o = en_i && armed_q && (cnt_q == '0);

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load_i) begin
      cnt_d   = load_val_i;
      armed_d = 1'b1;
    end else if (clear_i || expire_o) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (en_i && armed_q) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/lcd_host_ctrl.sv
// LCD command host: issues opcodes, streams the image on LOAD and captures each 16-pixel window.
module lcd_host_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            reset,
  lcd_host_ctrl_if.master bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e     state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [6:0] img_addr_q, img_addr_d;
  logic [6:0] load_cnt_q, load_cnt_d;
  logic [4:0] win_cnt_q, win_cnt_d;
  logic [7:0] pix_out_q, pix_out_d;
  logic [3:0] pix_idx_q, pix_idx_d;
  logic       pix_valid_q, pix_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       err_q, err_d;

  logic tmo_load, tmo_en, tmo_clr, tmo_expire;

  // Counter is reloaded on every entry into a waiting state, so ISSUE->COLLECT restarts it.
  assign tmo_en   = (state_q == ST_ISSUE) || (state_q == ST_COLLECT);
  assign tmo_load = (state_d != state_q) && ((state_d == ST_ISSUE) || (state_d == ST_COLLECT));
  assign tmo_clr  = !tmo_en;

  lcd_host_timeout #(.W(TW)) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmo_load),
    .load_val_i (TW'(TIMEOUT - 1)),
    .clear_i    (tmo_clr),
    .en_i       (tmo_en),
    .expire_o   (tmo_expire)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = cmd_valid_q;
    img_addr_d   = '0;
    load_cnt_d   = load_cnt_q;
    win_cnt_d    = win_cnt_q;
    pix_out_d    = pix_out_q;
    pix_idx_d    = pix_idx_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_cmd == CMD_BAD) begin
            err_d = 1'b1;
          end else begin
            cmd_d       = bus.req_cmd;
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (!bus.busy) begin
          cmd_valid_d = 1'b0;
          load_cnt_d  = '0;
          if (cmd_q == CMD_LOAD) begin
            img_addr_d = 7'd1;
            state_d    = ST_LOAD;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (tmo_expire) begin
          cmd_valid_d = 1'b0;
          err_d       = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Address runs one pixel ahead of load_cnt to cover the read latency.
        load_cnt_d = load_cnt_q + 7'd1;
        img_addr_d = load_cnt_q + 7'd2;
        if (load_cnt_q == 7'(IMG_PIX - 1)) begin
          load_cnt_d = '0;
          img_addr_d = '0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (tmo_expire) begin
          err_d     = 1'b1;
          win_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (bus.output_valid) begin
          pix_out_d   = bus.dataout;
          pix_idx_d   = win_cnt_q[3:0];
          pix_valid_d = 1'b1;
          win_cnt_d   = win_cnt_q + 5'd1;
          if (win_cnt_q == 5'(WIN_PIX - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        win_cnt_d    = '0;
        load_cnt_d   = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      img_addr_q   <= '0;
      load_cnt_q   <= '0;
      win_cnt_q    <= '0;
      pix_out_q    <= '0;
      pix_idx_q    <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      img_addr_q   <= img_addr_d;
      load_cnt_q   <= load_cnt_d;
      win_cnt_q    <= win_cnt_d;
      pix_out_q    <= pix_out_d;
      pix_idx_q    <= pix_idx_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.cmd         = cmd_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.img_addr    = img_addr_q;
  assign bus.datain      = (state_q == ST_LOAD) ? bus.img_rdata : '0;
  assign bus.pix_out     = pix_out_q;
  assign bus.pix_idx     = pix_idx_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_lcd_host_ctrl.sv
// Directed bench for lcd_host_ctrl: image ROM model plus hand-driven LCD responses.
module tb_lcd_host_ctrl;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] exp_pix;
    logic [3:0] exp_idx;
  } pix_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   pv_cnt = 0;
  int   fd_cnt = 0;
  int   to_cnt = 0;
  pix_vec_t vec [32];

  lcd_host_ctrl_if bus ();

  lcd_host_ctrl #(.TIMEOUT(256)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous image source: pixel n holds value n.
  always @(posedge clk) bus.img_rdata <= 8'(bus.img_addr);

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pix_valid)   pv_cnt <= pv_cnt + 1;
      if (bus.frame_done)  fd_cnt <= fd_cnt + 1;
      if (bus.err_timeout) to_cnt <= to_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op);
    bus.req_valid = 1'b1;
    bus.req_cmd   = op;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic collect(input int base, input int gap);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_no_pv", bus.pix_valid, 0);
      end
      bus.output_valid = 1'b1;
      bus.dataout      = vec[base+i].dout;
      tick();
      bus.output_valid = 1'b0;
      check("pix_valid", bus.pix_valid, 1);
      check("pix_out", bus.pix_out, vec[base+i].exp_pix);
      check("pix_idx", bus.pix_idx, vec[base+i].exp_idx);
      check("req_ready_busy", bus.req_ready, 0);
    end
    tick();
    check("frame_done", bus.frame_done, 1);
    check("req_ready_done", bus.req_ready, 1);
    tick();
    check("frame_done_pulse", bus.frame_done, 0);
  endtask

  task automatic do_load();
    issue(3'd0);
    check("load_cmd_valid", bus.cmd_valid, 1);
    check("load_cmd", bus.cmd, 0);
    tick();
    check("load_cmd_drop", bus.cmd_valid, 0);
    check("load_addr0", bus.img_addr, 1);
    for (int k = 0; k < 108; k++) begin
      check("load_datain", bus.datain, k);
      tick();
    end
    check("load_datain_end", bus.datain, 0);
    check("load_addr_end", bus.img_addr, 0);
  endtask

  initial begin
    int n;
    int hi;
    int pv0;
    int fd0;
    int to0;
    logic [7:0] fit [16];
    logic [7:0] zin [16];

    fit = '{8'd13, 8'd16, 8'd19, 8'd22, 8'd37, 8'd40, 8'd43, 8'd46,
            8'd61, 8'd64, 8'd67, 8'd70, 8'd85, 8'd88, 8'd91, 8'd94};
    zin = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd52, 8'd53, 8'd54, 8'd55,
            8'd64, 8'd65, 8'd66, 8'd67, 8'd76, 8'd77, 8'd78, 8'd79};
    for (int i = 0; i < 16; i++) begin
      vec[i]    = '{dout: fit[i], exp_pix: fit[i], exp_idx: 4'(i)};
      vec[16+i] = '{dout: zin[i], exp_pix: zin[i], exp_idx: 4'(i)};
    end

    bus.req_valid    = 1'b0;
    bus.req_cmd      = '0;
    bus.busy         = 1'b0;
    bus.dataout      = '0;
    bus.output_valid = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cmd", bus.cmd, 0);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_datain", bus.datain, 0);
    check("rst_img_addr", bus.img_addr, 0);
    check("rst_pix", {bus.pix_out, bus.pix_idx, bus.pix_valid}, 0);
    check("rst_flags", {bus.frame_done, bus.err_timeout}, 0);
    check("rst_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    tick();

    // Load, then zoom-fit window from the LCD model
    fd0 = fd_cnt;
    do_load();
    collect(0, 0);
    check("fit_fd_count", fd_cnt - fd0, 1);

    // Zoom-in with gaps between LCD pixels
    issue(3'd1);
    check("zin_cmd", bus.cmd, 1);
    check("zin_req_ready", bus.req_ready, 0);
    tick();
    collect(16, 1);

    // Busy held for 20 ISSUE cycles
    bus.busy = 1'b1;
    issue(3'd3);
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.cmd_valid) hi++;
      tick();
    end
    bus.busy = 1'b0;
    if (bus.cmd_valid) hi++;
    tick();
    check("busy_cmd_valid_cycles", hi, 21);
    check("busy_accept_drop", bus.cmd_valid, 0);
    collect(0, 0);

    // Shift-up never answered: timeout in COLLECT
    pv0 = pv_cnt;
    to0 = to_cnt;
    issue(3'd5);
    tick();
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (bus.err_timeout) break;
    end
    check("up_timeout_cycles", n, 256);
    check("up_cmd_valid", bus.cmd_valid, 0);
    check("up_req_ready", bus.req_ready, 1);
    tick();
    check("up_no_pix", pv_cnt - pv0, 0);
    check("up_err_pulses", to_cnt - to0, 1);

    // Command never accepted: timeout in ISSUE
    bus.busy = 1'b1;
    issue(3'd6);
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (bus.err_timeout) break;
    end
    bus.busy = 1'b0;
    check("issue_timeout_cycles", n, 256);
    check("issue_timeout_cmd_valid", bus.cmd_valid, 0);
    check("issue_timeout_ready", bus.req_ready, 1);

    // Pixel on the expiry cycle is dropped
    pv0 = pv_cnt;
    issue(3'd4);
    tick();
    for (int c = 0; c < 255; c++) tick();
    bus.output_valid = 1'b1;
    bus.dataout      = 8'hAA;
    tick();
    bus.output_valid = 1'b0;
    check("tie_err", bus.err_timeout, 1);
    check("tie_pix_valid", bus.pix_valid, 0);
    tick();
    check("tie_no_pix", pv_cnt - pv0, 0);

    // Opcode 7 dropped
    issue(3'd7);
    check("op7_err", bus.err_timeout, 1);
    check("op7_ready", bus.req_ready, 1);
    check("op7_cmd_valid", bus.cmd_valid, 0);
    tick();
    check("op7_err_pulse", bus.err_timeout, 0);

    // Reset during LOAD at load_cnt=50
    issue(3'd0);
    tick();
    for (int c = 0; c < 50; c++) tick();
    check("mid_datain", bus.datain, 50);
    rst_n = 1'b0;
    #1;
    check("mid_rst_datain", bus.datain, 0);
    check("mid_rst_addr", bus.img_addr, 0);
    check("mid_rst_cmd", {bus.cmd, bus.cmd_valid}, 0);
    check("mid_rst_flags", {bus.pix_valid, bus.frame_done, bus.err_timeout}, 0);
    check("mid_rst_ready", bus.req_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    do_load();

    // 18 LCD pulses: only 16 captured
    pv0 = pv_cnt;
    fd0 = fd_cnt;
    for (int i = 0; i < 18; i++) begin
      bus.output_valid = 1'b1;
      bus.dataout      = 8'(i);
      tick();
    end
    bus.output_valid = 1'b0;
    tick();
    tick();
    check("extra_pv_count", pv_cnt - pv0, 16);
    check("extra_fd_count", fd_cnt - fd0, 1);
    check("extra_ready", bus.req_ready, 1);
    check("extra_last_idx", bus.pix_idx, 15);
    check("extra_last_pix", bus.pix_out, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
